mem_wb_skid_stage: RTL and testbench
====================================

# mem_wb_skid_stage

Parametrised MEM/WB pipeline stage with a valid/ready handshake and a two-entry skid buffer. It carries the RAM read data, the ALU/immediate result, the PC, the destination register and the WB control fields from the MEM stage to the write-back stage. It adds stall back-pressure, a flush that squashes in-flight entries, halt tracking, and an optional forwarding tap that feeds the hazard unit.

## Interface
- DATA_W, 32, width of the RAM data, immediate/ALU data and PC fields
- RADDR_W, 5, width of the destination register address
- SEL_W, 2, width of the MemtoReg select (minimum 2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  stage can accept an entry this cycle
- in_ram_data, in_imm_data, in_pc  in  DATA_W each  payload
- in_rd  in  RADDR_W  destination register
- in_regwrite  in  1; in_memtoreg  in  SEL_W; in_halt  in  1  WB control
- flush  in  1  squash all held entries
- out_valid  out  1  WB-side entry valid
- out_ready  in  1  WB stage consumes the entry
- out_ram_data, out_imm_data, out_pc, out_rd, out_memtoreg  out  payload of head entry
- out_regwrite  out  1  head regwrite AND out_valid
- out_halt  out  1  head halt AND out_valid
- halted  out  1  sticky; a halt entry has been consumed
- fwd_valid  out  1, fwd_rd  out  RADDR_W, fwd_data  out  DATA_W  (only with MEM_WB_FWD_EN)

## Operation
- Storage: head entry (drives out_*) and skid entry, each with a valid bit. Both are always registered.
- in_ready = !skid_valid && !halt_seen && !rst. It is a pure function of registered state, with no combinational path from out_ready.
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- Head empty, or head popping while skid is empty: an accepted entry loads the head.
- Head full and not popping: an accepted entry loads the skid.
- Pop while skid is full: skid moves to the head and the skid is cleared. in_ready is 0 that cycle, so no simultaneous accept is possible.
- Order is strictly FIFO. No entry is lost or duplicated.
- halt_seen is set when an entry with in_halt=1 is accepted. It blocks all further accepts.
- halted is set when an entry with halt=1 pops. It is cleared only by rst.
- flush: on the next edge both valid bits and halt_seen clear. Any accept or pop in the flush cycle is discarded; a pop in that cycle does not set halted.
- flush does not clear halted.
- Payload registers of invalid entries hold stale values. out_regwrite and out_halt are gated to 0 whenever out_valid=0.

## Timing
- Reset values: out_valid=0, all out_* payloads=0, out_regwrite=0, out_halt=0, halted=0, halt_seen=0, skid empty.
- in_ready=0 during rst and 1 in the first cycle after rst deasserts.
- Latency: accept at edge N gives out_valid=1 after edge N, i.e. 1 cycle.
- Throughput is one entry per cycle while out_ready=1.
- After out_ready falls, at most one more entry is accepted (into the skid), then in_ready falls.
- When out_ready rises with skid full: pop, skid to head, and in_ready returns to 1 the following cycle.
- rst has priority over flush. flush has priority over accept and pop.
- rst mid-operation drops all entries at that edge.

## Configuration
- MEM_WB_FWD_EN defined: adds registered-path-free forwarding outputs derived from the head entry.
  - fwd_valid = out_valid && out_regwrite && (out_rd != 0).
  - fwd_rd = out_rd.
  - fwd_data selected by out_memtoreg: 0 gives imm_data, 1 gives ram_data, 2 gives pc, other codes give imm_data.
- MEM_WB_FWD_EN undefined: fwd_* ports are absent and no select logic is built.
- Handshake behaviour is identical in both builds.

## Test plan
- Reset then stream 4 entries (pc=0x0,0x4,0x8,0xC) with out_ready=1 -> out_pc=0x0..0xC on consecutive cycles, each 1 cycle after accept; in_ready stays 1.
- Drop out_ready after the first entry while in_valid=1 -> entry 2 goes into the skid and in_ready=0. Raising out_ready -> entries 2,3 emerge in order with none lost or duplicated.
- Accept an entry with in_halt=1, rd=5, then hold in_valid=1 -> in_ready=0 from the next cycle. out_halt=1 on the pop, halted=1 afterwards, and no further entry is accepted.
- Fill head and skid, then assert flush for 1 cycle -> out_valid=0, out_regwrite=0, in_ready=1 next cycle, halted unchanged. A halt entry flushed from the skid leaves halted=0.
- MEM_WB_FWD_EN build, head rd=3, regwrite=1, memtoreg=1, ram_data=0xDEADBEEF -> fwd_valid=1, fwd_data=0xDEADBEEF. With rd=0 -> fwd_valid=0. With memtoreg=2 -> fwd_data=out_pc.
- Assert rst with 2 entries held -> all outputs 0 after the edge, in_ready=1 one cycle after rst falls.

Source files
------------

// File: rtl/mem_wb_skid_stage_if.sv
// mem_wb_skid_stage_if: MEM->WB handshake bus (in_* MEM side, out_* WB side, flush, halted, optional fwd_* tap under MEM_WB_FWD_EN); slave = stage, master = environment
interface mem_wb_skid_stage_if #(parameter int DATA_W = 32, parameter int RADDR_W = 5, parameter int SEL_W = 2);
  logic               in_valid, in_ready, in_regwrite, in_halt;
  logic [DATA_W-1:0]  in_ram_data, in_imm_data, in_pc;
  logic [RADDR_W-1:0] in_rd;
  logic [SEL_W-1:0]   in_memtoreg;
  logic               flush, halted;
  logic               out_valid, out_ready, out_regwrite, out_halt;
  logic [DATA_W-1:0]  out_ram_data, out_imm_data, out_pc;
  logic [RADDR_W-1:0] out_rd;
  logic [SEL_W-1:0]   out_memtoreg;
`ifdef MEM_WB_FWD_EN
  logic               fwd_valid;
  logic [RADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0]  fwd_data;
`endif
  modport slave (
    input  in_valid, in_ram_data, in_imm_data, in_pc, in_rd, in_regwrite, in_memtoreg, in_halt, flush, out_ready,
    output in_ready, out_valid, out_ram_data, out_imm_data, out_pc, out_rd, out_regwrite, out_memtoreg, out_halt, halted
`ifdef MEM_WB_FWD_EN
    , output fwd_valid, fwd_rd, fwd_data
`endif
  );
  modport master (
    output in_valid, in_ram_data, in_imm_data, in_pc, in_rd, in_regwrite, in_memtoreg, in_halt, flush, out_ready,
    input  in_ready, out_valid, out_ram_data, out_imm_data, out_pc, out_rd, out_regwrite, out_memtoreg, out_halt, halted
`ifdef MEM_WB_FWD_EN
    , input fwd_valid, fwd_rd, fwd_data
`endif
  );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM/WB stage with head+skid buffer, flush, halt tracking; ports clk, rst, bus (slave); MEM_WB_FWD_EN adds fwd_* tap
module mem_wb_skid_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int SEL_W   = 2
) (
  input logic clk,
  input logic rst,
  mem_wb_skid_stage_if.slave bus
);
  typedef struct packed {
    logic [DATA_W-1:0]  ram, imm, pc;
    logic [RADDR_W-1:0] rd;
    logic               rw;
    logic [SEL_W-1:0]   m2r;
    logic               halt;
  } entry_t;
  entry_t head_q, head_d, skid_q, skid_d, in_e;
  logic head_v_q, head_v_d, skid_v_q, skid_v_d, halt_seen_q, halt_seen_d, halted_q, halted_d, acc, pop;
  assign in_e = {bus.in_ram_data, bus.in_imm_data, bus.in_pc, bus.in_rd, bus.in_regwrite, bus.in_memtoreg, bus.in_halt};
  assign bus.in_ready = !skid_v_q && !halt_seen_q && !rst;
  assign acc = bus.in_valid && bus.in_ready;
  assign pop = head_v_q && bus.out_ready;
  always_comb begin
    head_d      = head_q;
    skid_d      = skid_q;
    head_v_d    = head_v_q;
    skid_v_d    = skid_v_q;
    halt_seen_d = halt_seen_q || (acc && in_e.halt);
    halted_d    = halted_q || (pop && head_q.halt);
    if (bus.flush) begin
      head_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      halt_seen_d = 1'b0;
      halted_d    = halted_q;
    end else if (pop && skid_v_q) begin
      head_d   = skid_q;
      skid_v_d = 1'b0;
    end else if (acc && (!head_v_q || pop)) begin
      head_d   = in_e;
      head_v_d = 1'b1;
    end else if (acc) begin
      skid_d   = in_e;
      skid_v_d = 1'b1;
    end else if (pop) begin
      head_v_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      skid_q      <= '0;
      head_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      head_q      <= head_d;
      skid_q      <= skid_d;
      head_v_q    <= head_v_d;
      skid_v_q    <= skid_v_d;
      halt_seen_q <= halt_seen_d;
      halted_q    <= halted_d;
    end
  end
  assign bus.out_valid    = head_v_q;
  assign bus.out_ram_data = head_q.ram;
  assign bus.out_imm_data = head_q.imm;
  assign bus.out_pc       = head_q.pc;
  assign bus.out_rd       = head_q.rd;
  assign bus.out_memtoreg = head_q.m2r;
  assign bus.out_regwrite = head_q.rw && head_v_q;
  assign bus.out_halt     = head_q.halt && head_v_q;
  assign bus.halted       = halted_q;
`ifdef MEM_WB_FWD_EN
  assign bus.fwd_valid = head_v_q && head_q.rw && (head_q.rd != '0);
  assign bus.fwd_rd    = head_q.rd;
  assign bus.fwd_data  = (head_q.m2r == SEL_W'(1)) ? head_q.ram :
                         (head_q.m2r == SEL_W'(2)) ? head_q.pc : head_q.imm;
`endif
endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// tb_mem_wb_skid_stage: randomized + directed bench against a queue-based reference model
module tb_mem_wb_skid_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mem_wb_skid_stage_if #(.DATA_W(32), .RADDR_W(5), .SEL_W(2)) bus ();
  mem_wb_skid_stage #(.DATA_W(32), .RADDR_W(5), .SEL_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] ram, imm, pc;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  m2r;
    logic        halt;
  } ent_t;
  ent_t q[$];
  logic m_halt_seen = 1'b0;
  logic m_halted = 1'b0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_outputs(input logic r);
    chk("in_ready", 64'(bus.in_ready), 64'(!r && q.size() < 2 && !m_halt_seen));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("halted", 64'(bus.halted), 64'(m_halted));
    if (q.size() > 0) begin
      chk("out_pc", 64'(bus.out_pc), 64'(q[0].pc));
      chk("out_ram", 64'(bus.out_ram_data), 64'(q[0].ram));
      chk("out_imm", 64'(bus.out_imm_data), 64'(q[0].imm));
      chk("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
      chk("out_m2r", 64'(bus.out_memtoreg), 64'(q[0].m2r));
      chk("out_rw", 64'(bus.out_regwrite), 64'(q[0].rw));
      chk("out_halt", 64'(bus.out_halt), 64'(q[0].halt));
`ifdef MEM_WB_FWD_EN
      chk("fwd_valid", 64'(bus.fwd_valid), 64'(q[0].rw && q[0].rd != 0));
      chk("fwd_rd", 64'(bus.fwd_rd), 64'(q[0].rd));
      chk("fwd_data", 64'(bus.fwd_data), 64'(q[0].m2r == 1 ? q[0].ram : q[0].m2r == 2 ? q[0].pc : q[0].imm));
`endif
    end else begin
      chk("out_rw_idle", 64'(bus.out_regwrite), 64'd0);
      chk("out_halt_idle", 64'(bus.out_halt), 64'd0);
`ifdef MEM_WB_FWD_EN
      chk("fwd_valid_idle", 64'(bus.fwd_valid), 64'd0);
`endif
    end
  endtask
  task automatic cycle(input logic v, input logic ordy, input logic fl, input logic r, input ent_t e);
    logic acc, pop;
    bus.in_valid = v; bus.out_ready = ordy; bus.flush = fl; rst = r;
    bus.in_ram_data = e.ram; bus.in_imm_data = e.imm; bus.in_pc = e.pc; bus.in_rd = e.rd;
    bus.in_regwrite = e.rw; bus.in_memtoreg = e.m2r; bus.in_halt = e.halt;
    #1;
    check_outputs(r);
    acc = v && !r && q.size() < 2 && !m_halt_seen;
    pop = q.size() > 0 && ordy;
    if (r) begin
      q.delete(); m_halt_seen = 1'b0; m_halted = 1'b0;
    end else if (fl) begin
      q.delete(); m_halt_seen = 1'b0;
    end else begin
      if (pop) begin
        if (q[0].halt) m_halted = 1'b1;
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(e);
        if (e.halt) m_halt_seen = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic ent_t mk(input logic [31:0] pc, input logic h);
    ent_t e;
    e.ram = $urandom; e.imm = $urandom; e.pc = pc; e.rd = 5'($urandom);
    e.rw = 1'($urandom); e.m2r = 2'($urandom); e.halt = h;
    return e;
  endfunction
  task automatic go(input logic v, input logic ordy, input logic fl, input logic [31:0] pc, input logic h);
    cycle(v, ordy, fl, 1'b0, mk(pc, h));
  endtask
  task automatic check_zero_payload();
    chk("rst_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_ram", 64'(bus.out_ram_data), 64'd0);
    chk("rst_imm", 64'(bus.out_imm_data), 64'd0);
    chk("rst_rd", 64'(bus.out_rd), 64'd0);
    chk("rst_m2r", 64'(bus.out_memtoreg), 64'd0);
  endtask
  initial begin
    ent_t e;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    bus.in_ram_data = '0; bus.in_imm_data = '0; bus.in_pc = '0; bus.in_rd = '0;
    bus.in_regwrite = 1'b0; bus.in_memtoreg = '0; bus.in_halt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs(1'b1);
    check_zero_payload();
    for (int i = 0; i < 4; i++) go(1'b1, 1'b1, 1'b0, 32'(i * 4), 1'b0);
    go(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    go(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    go(1'b1, 1'b1, 1'b0, 32'h10, 1'b0);
    go(1'b1, 1'b0, 1'b0, 32'h14, 1'b0);
    go(1'b1, 1'b0, 1'b0, 32'h18, 1'b0);
    go(1'b1, 1'b0, 1'b0, 32'h1C, 1'b0);
    for (int i = 0; i < 3; i++) go(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    e = mk(32'h20, 1'b1); e.rd = 5'd5;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, e);
    for (int i = 0; i < 3; i++) go(1'b1, 1'b0, 1'b0, 32'h24, 1'b0);
    for (int i = 0; i < 3; i++) go(1'b1, 1'b1, 1'b0, 32'h28, 1'b0);
    go(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    go(1'b1, 1'b0, 1'b0, 32'h30, 1'b0);
    go(1'b1, 1'b0, 1'b0, 32'h34, 1'b0);
    go(1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0, 1'b0));
    go(1'b1, 1'b0, 1'b0, 32'h40, 1'b0);
    go(1'b1, 1'b0, 1'b0, 32'h44, 1'b1);
    go(1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
    go(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    go(1'b1, 1'b0, 1'b0, 32'h50, 1'b0);
    go(1'b1, 1'b0, 1'b0, 32'h54, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, mk(32'h58, 1'b0));
    check_zero_payload();
    go(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef MEM_WB_FWD_EN
    e = mk(32'h60, 1'b0); e.rd = 5'd3; e.rw = 1'b1; e.m2r = 2'd1; e.ram = 32'hDEADBEEF;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, e);
    e.rd = 5'd0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, e);
    e.rd = 5'd7; e.m2r = 2'd2;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, e);
    go(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
`endif
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) == 0, mk($urandom, $urandom_range(0, 11) == 0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
